// File: rtl/decode_stage.sv
// Registered opcode decode with valid/ready output slot and load-use bubbles.
// DECODE_LOADUSE_INTERLOCK_EN builds the load-destination scoreboard.
module decode_stage #(
    parameter int OPC_W  = 5,
    parameter int REG_AW = 4,
    parameter int RA_IDX = 15,
    parameter int LD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_ctrl,
    output logic [OPC_W-1:0]  out_aluop,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic              out_illegal,
    output logic              hazard_stall
);
    localparam int IB = 31 - OPC_W;

    localparam int C_RET  = 11;
    localparam int C_ST   = 10;
    localparam int C_WB   = 9;
    localparam int C_IMM  = 8;
    localparam int C_BEQ  = 7;
    localparam int C_BGT  = 6;
    localparam int C_UBR  = 5;
    localparam int C_LD   = 4;
    localparam int C_CALL = 3;
    localparam int C_IRET = 2;
    localparam int C_SET  = 1;
    localparam int C_RST  = 0;

    localparam logic [OPC_W-1:0] OP_ALU_HI = OPC_W'(5'h04);
    localparam logic [OPC_W-1:0] OP_CMP    = OPC_W'(5'h05);
    localparam logic [OPC_W-1:0] OP_ALU2   = OPC_W'(5'h06);
    localparam logic [OPC_W-1:0] OP_NOT    = OPC_W'(5'h08);
    localparam logic [OPC_W-1:0] OP_MOV    = OPC_W'(5'h09);
    localparam logic [OPC_W-1:0] OP_ALU2HI = OPC_W'(5'h0C);
    localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(5'h0D);
    localparam logic [OPC_W-1:0] OP_LD     = OPC_W'(5'h0E);
    localparam logic [OPC_W-1:0] OP_ST     = OPC_W'(5'h0F);
    localparam logic [OPC_W-1:0] OP_BEQ    = OPC_W'(5'h10);
    localparam logic [OPC_W-1:0] OP_BGT    = OPC_W'(5'h11);
    localparam logic [OPC_W-1:0] OP_B      = OPC_W'(5'h12);
    localparam logic [OPC_W-1:0] OP_CALL   = OPC_W'(5'h13);
    localparam logic [OPC_W-1:0] OP_RET    = OPC_W'(5'h14);
    localparam logic [OPC_W-1:0] OP_IRET   = OPC_W'(5'h15);
    localparam logic [OPC_W-1:0] OP_SET    = OPC_W'(5'h18);
    localparam logic [OPC_W-1:0] OP_RESET  = OPC_W'(5'h19);

    logic [OPC_W-1:0]  opc;
    logic              imm;
    logic [REG_AW-1:0] rd, rs1, rs2, src1;
    logic              is_alu;
    logic [11:0]       dctrl;
    logic              dill, u1, u2, ud;
    logic              hazard, advance, accept;
    logic              unused_low;

    assign opc = in_instr[31 -: OPC_W];
    assign imm = in_instr[IB];
    assign rd  = in_instr[IB-1 -: REG_AW];
    assign rs1 = in_instr[IB-1-REG_AW -: REG_AW];
    assign rs2 = in_instr[IB-1-2*REG_AW -: REG_AW];
    assign unused_low = ^in_instr[IB-3*REG_AW-1:0];

    assign is_alu = (opc <= OP_ALU_HI) || (opc >= OP_ALU2 && opc <= OP_ALU2HI);
    // ret pulls its target from the return-address register
    assign src1 = (opc == OP_RET) ? REG_AW'(RA_IDX) : rs1;

    always_comb begin
        dctrl = '0;
        dill  = 1'b0;
        u1    = 1'b0;
        u2    = 1'b0;
        ud    = 1'b0;
        unique case (1'b1)
            is_alu: begin
                dctrl[C_WB] = 1'b1;
                u1 = (opc != OP_MOV) && (opc != OP_NOT);
                u2 = !imm;
            end
            opc == OP_CMP: begin
                u1 = 1'b1;
                u2 = !imm;
            end
            opc == OP_NOP: begin
            end
            opc == OP_LD: begin
                dctrl[C_WB] = 1'b1;
                dctrl[C_LD] = 1'b1;
                u1 = 1'b1;
            end
            opc == OP_ST: begin
                dctrl[C_ST] = 1'b1;
                u1 = 1'b1;
                ud = 1'b1;
            end
            opc == OP_BEQ: dctrl[C_BEQ] = 1'b1;
            opc == OP_BGT: dctrl[C_BGT] = 1'b1;
            opc == OP_B:   dctrl[C_UBR] = 1'b1;
            opc == OP_CALL: begin
                dctrl[C_WB]   = 1'b1;
                dctrl[C_UBR]  = 1'b1;
                dctrl[C_CALL] = 1'b1;
            end
            opc == OP_RET: begin
                dctrl[C_RET] = 1'b1;
                dctrl[C_UBR] = 1'b1;
                u1 = 1'b1;
            end
            opc == OP_IRET: begin
                dctrl[C_RET]  = 1'b1;
                dctrl[C_UBR]  = 1'b1;
                dctrl[C_IRET] = 1'b1;
            end
            opc == OP_SET: begin
                dctrl[C_WB]  = 1'b1;
                dctrl[C_SET] = 1'b1;
            end
            opc == OP_RESET: begin
                dctrl[C_WB]  = 1'b1;
                dctrl[C_RST] = 1'b1;
            end
            default: dill = 1'b1;
        endcase
        dctrl[C_IMM] = imm;
    end

    assign advance      = !out_valid || out_ready;
    assign in_ready     = advance && !hazard && !flush;
    assign accept       = in_valid && in_ready;
    assign hazard_stall = in_valid && hazard && advance && !flush;

`ifdef DECODE_LOADUSE_INTERLOCK_EN
    logic [LD_LAT-1:0] sb_v;
    logic [REG_AW-1:0] sb_rd [LD_LAT];

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LD_LAT; i++) begin
            if (sb_v[i] && ((u1 && src1 == sb_rd[i]) ||
                            (u2 && rs2 == sb_rd[i]) ||
                            (ud && rd == sb_rd[i])))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v <= '0;
            for (int i = 0; i < LD_LAT; i++) sb_rd[i] <= '0;
        end else if (flush) begin
            sb_v <= '0;
        end else if (advance) begin
            sb_v[0]  <= accept && dctrl[C_LD];
            sb_rd[0] <= rd;
            for (int i = 1; i < LD_LAT; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{u1, u2, ud};
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_aluop   <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_aluop   <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_illegal <= 1'b0;
        end else if (advance) begin
            out_valid   <= accept;
            out_ctrl    <= accept ? dctrl : '0;
            out_aluop   <= accept ? opc : '0;
            out_rd      <= accept ? rd : '0;
            out_rs1     <= accept ? src1 : '0;
            out_rs2     <= accept ? rs2 : '0;
            out_illegal <= accept && dill;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances, LD_LAT=1 and LD_LAT=3.
module tb_decode_stage;
    localparam logic [31:0] ADD   = 32'h014C8000;
    localparam logic [31:0] LD    = 32'h74C40004;
    localparam logic [31:0] INDEP = 32'h01848000;
    localparam logic [31:0] RET   = 32'hA0000000;
    localparam logic [31:0] ILL   = 32'hF8000000;
`ifdef DECODE_LOADUSE_INTERLOCK_EN
    localparam int IL = 1;
`else
    localparam int IL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fl [2];
    logic        iv [2];
    logic        ordy [2];
    logic [31:0] ii [2];
    logic        ir [2];
    logic        ov [2];
    logic        ill [2];
    logic        hs [2];
    logic [11:0] ctl [2];
    logic [4:0]  aop [2];
    logic [3:0]  rd [2];
    logic [3:0]  r1 [2];
    logic [3:0]  r2 [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.LD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_instr(ii[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(ctl[0]),
        .out_aluop(aop[0]), .out_rd(rd[0]), .out_rs1(r1[0]),
        .out_rs2(r2[0]), .out_illegal(ill[0]), .hazard_stall(hs[0])
    );

    decode_stage #(.LD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_instr(ii[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(ctl[1]),
        .out_aluop(aop[1]), .out_rd(rd[1]), .out_rs1(r1[1]),
        .out_rs2(r2[1]), .out_illegal(ill[1]), .hazard_stall(hs[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] ins,
                         input logic r, input logic f);
        @(negedge clk);
        iv[d]   = v;
        ii[d]   = ins;
        ordy[d] = r;
        fl[d]   = f;
        #1;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 5; i++) drive(d, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic ld_use(input int d, input int gap, input int expb);
        int b;
        drain(d);
        drive(d, 1'b1, LD, 1'b1, 1'b0);
        check("ld_ready", ir[d], 1);
        for (int g = 0; g < gap; g++) begin
            drive(d, 1'b1, INDEP, 1'b1, 1'b0);
            check("indep_ready", ir[d], 1);
        end
        b = 0;
        drive(d, 1'b1, ADD, 1'b1, 1'b0);
        while (!ir[d] && b < 10) begin
            check("stall_flag", hs[d], 1);
            b++;
            drive(d, 1'b1, ADD, 1'b1, 1'b0);
            check("bubble_valid", ov[d], 0);
        end
        check("bubbles", b, expb);
        check("no_stall", hs[d], 0);
        drive(d, 1'b0, 32'h0, 1'b1, 1'b0);
        check("add_valid", ov[d], 1);
        check("add_rd", rd[d], 5);
        check("add_rs1", r1[d], 3);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            fl[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1; ii[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        check("rst_valid", ov[0], 0);
        check("rst_ctrl", ctl[0], 0);
        check("rst_rd", rd[0], 0);
        check("rst_ill", ill[1], 0);
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("rst_ready", ir[0], 1);

        // basic add
        drive(0, 1'b1, ADD, 1'b1, 1'b0);
        check("add_accept", ir[0], 1);
        drive(0, 1'b1, LD, 1'b1, 1'b0);
        check("add_v", ov[0], 1);
        check("add_ctrl", ctl[0], 12'h200);
        check("add_op", aop[0], 0);
        check("add_rd0", rd[0], 5);
        check("add_rs1_0", r1[0], 3);
        check("add_rs2_0", r2[0], 2);
        check("add_ir", ir[0], 1);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("ld_ctrl", ctl[0], 12'h310);
        check("ld_op", aop[0], 5'h0E);
        check("ld_rd", rd[0], 3);
        check("ld_rs1", r1[0], 1);

        // ret and illegal
        drain(0);
        drive(0, 1'b1, RET, 1'b1, 1'b0);
        drive(0, 1'b1, ILL, 1'b1, 1'b0);
        check("ret_ctrl", ctl[0], 12'h820);
        check("ret_rs1", r1[0], 15);
        check("ret_ill", ill[0], 0);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("ill_flag", ill[0], 1);
        check("ill_ctrl", ctl[0], 0);
        check("ill_valid", ov[0], 1);

        // load-use
        ld_use(0, 0, IL ? 1 : 0);
        ld_use(1, 0, IL ? 3 : 0);
        ld_use(1, 1, IL ? 2 : 0);
        ld_use(0, 1, 0);

        // downstream stall
        drain(0);
        drive(0, 1'b1, ADD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, INDEP, 1'b0, 1'b0);
            check("hold_valid", ov[0], 1);
            check("hold_rd", rd[0], 5);
            check("hold_ready", ir[0], 0);
        end
        drive(0, 1'b1, INDEP, 1'b1, 1'b0);
        check("resume_ready", ir[0], 1);
        check("resume_rd", rd[0], 5);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("next_valid", ov[0], 1);
        check("next_rd", rd[0], 6);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("no_dup", ov[0], 0);

        // scoreboard frozen under stall
        drain(0);
        drive(0, 1'b1, LD, 1'b1, 1'b0);
        drive(0, 1'b1, ADD, 1'b0, 1'b0);
        drive(0, 1'b1, ADD, 1'b0, 1'b0);
        check("frz_hs", hs[0], 0);
        check("frz_ir", ir[0], 0);
        drive(0, 1'b1, ADD, 1'b1, 1'b0);
        check("frz_hs2", hs[0], IL ? 1 : 0);
        check("frz_ir2", ir[0], IL ? 0 : 1);

        // flush clears held ld and scoreboard
        drain(0);
        drive(0, 1'b1, LD, 1'b1, 1'b0);
        drive(0, 1'b1, ADD, 1'b0, 1'b0);
        check("pre_flush_v", ov[0], 1);
        drive(0, 1'b1, ADD, 1'b1, 1'b1);
        check("flush_ir", ir[0], 0);
        check("flush_hs", hs[0], 0);
        drive(0, 1'b1, ADD, 1'b1, 1'b0);
        check("post_flush_v", ov[0], 0);
        check("post_flush_ir", ir[0], 1);
        check("post_flush_hs", hs[0], 0);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("post_flush_add", rd[0], 5);
        check("post_flush_ov", ov[0], 1);

        // reset mid-hazard
        drain(1);
        drive(1, 1'b1, LD, 1'b1, 1'b0);
        drive(1, 1'b1, ADD, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_valid", ov[1], 0);
        check("arst_ir", ir[1], 1);
        drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        drive(1, 1'b1, ADD, 1'b1, 1'b0);
        check("arst_clear", ir[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
